// File: rtl/y_chg_pkg.sv
// Shared definitions for the change-in-Y path: sequencer state encoding,
// sentinel/invalid markers and the Y-memory geometry used by the decoder,
// the memory wrapper and the fetch sequencer.
package y_chg_pkg;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 11;

  localparam logic [15:0] ROW_SENTINEL = 16'hFFFF;
  localparam logic [10:0] ADDR_INVALID = 11'h7FF;

  typedef enum logic [3:0] {
    IDLE,
    IDX,
    IDX_RD,
    WAIT,
    RESOLVE,
    RD0,
    RD1,
    CAP,
    OUT
  } state_t;

endpackage

// File: rtl/y_fetch_sequencer.sv
// y_fetch_sequencer
// Steps the Y address decoder through its two-phase lookup for each change
// entry and owns the single Y-memory read port: one index-row read, then the
// two data-line reads. The resulting line pair is offered downstream.
//
// Ports:
//   clock, reset            clock; synchronous active-low reset
//   chg_valid/ready/row/col change-entry input handshake
//   dec_rowNum              row to decoder (all-ones parks it in phase 1)
//   dec_readRowData         index-row data to decoder (RESOLVE only)
//   dec_addr1/addr2         decoder address results
//   dec_dataOutNextCycle    decoder phase-1 indicator
//   mem_rd_en/addr/data     Y-memory read port, one-cycle read latency
//   out_valid/ready         line-pair output handshake
//   out_line0/line1         lines at addr1 / addr2
//   out_row/col/addr0       echo of the entry and its first line address
//   done                    one-cycle pulse when the end sentinel is consumed
//   err                     sticky: decoder desync or invalid address
module y_fetch_sequencer #(
  parameter int ROW_W  = 16,
  parameter int COL_W  = 16,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              chg_valid,
  output logic              chg_ready,
  input  logic [ROW_W-1:0]  chg_row,
  input  logic [COL_W-1:0]  chg_col,
  output logic [ROW_W-1:0]  dec_rowNum,
  output logic [DATA_W-1:0] dec_readRowData,
  input  logic [ADDR_W-1:0] dec_addr1,
  input  logic [ADDR_W-1:0] dec_addr2,
  input  logic              dec_dataOutNextCycle,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_line0,
  output logic [DATA_W-1:0] out_line1,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic [ADDR_W-1:0] out_addr0,
  output logic              done,
  output logic              err
);

  import y_chg_pkg::*;

  localparam logic [ADDR_W-1:0] BAD_ADDR = ADDR_W'(ADDR_INVALID);

  state_t            state;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [DATA_W-1:0] idx_data;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;

  assign chg_ready = (state == IDLE);

  // The decoder sees the held row only while the lookup is in progress;
  // all-ones everywhere else returns it to phase 1 before the next entry.
  always_comb begin
    dec_rowNum      = '1;
    dec_readRowData = '0;
    if (state inside {IDX, IDX_RD, WAIT, RESOLVE}) begin
      dec_rowNum = row_q;
    end
    if (state == RESOLVE) begin
      dec_readRowData = idx_data;
    end
  end

  // Reads in IDX_RD and RD0 use the decoder outputs of the same cycle,
  // since the addresses only become valid there.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    unique case (state)
      IDX_RD: begin
        mem_rd_en   = dec_dataOutNextCycle;
        mem_rd_addr = dec_addr1;
      end
      RD0: begin
        mem_rd_en   = (dec_addr1 != BAD_ADDR);
        mem_rd_addr = dec_addr1;
      end
      RD1: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = a1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      idx_data  <= '0;
      a0        <= '0;
      a1        <= '0;
      out_valid <= 1'b0;
      out_line0 <= '0;
      out_line1 <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_addr0 <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (chg_valid) begin
            row_q <= chg_row;
            col_q <= chg_col;
            if (&chg_row) begin
              done <= 1'b1;
            end else begin
              state <= IDX;
            end
          end
        end
        IDX: state <= IDX_RD;
        IDX_RD: begin
          if (!dec_dataOutNextCycle) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          idx_data <= mem_rd_data;
          state    <= RESOLVE;
        end
        RESOLVE: state <= RD0;
        RD0: begin
          a0 <= dec_addr1;
          a1 <= dec_addr2;
          if (dec_addr1 == BAD_ADDR) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            state <= RD1;
          end
        end
        RD1: begin
          out_line0 <= mem_rd_data;
          state     <= CAP;
        end
        CAP: begin
          out_line1 <= mem_rd_data;
          out_row   <= row_q;
          out_col   <= col_q;
          out_addr0 <= a0;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
